// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/framing checks and a
// show-ahead output FIFO. Line config is captured at each start bit.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_data,
  input  logic [DIV_W-1:0]     i_clks_per_bit,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t               state, state_n;
  logic                 sync1, rxs;
  logic [DIV_W-1:0]     cnt, div, half, div_eff;
  logic                 par_en, par_odd, two_stop, armed;
  logic                 smp_a, smp_b, maj_r, par_err, frame_err;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 maj, bit_val, at_mid, at_end, done;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= i_rx_data;
      rxs   <= sync1;
    end
  end

  assign div_eff = (i_clks_per_bit < DIV_W'(4)) ? DIV_W'(4) : i_clks_per_bit;
  assign half    = div >> 1;
  assign at_mid  = (cnt == half + DIV_W'(1));
  assign at_end  = (cnt == div - DIV_W'(1));
  // Third sample is the live line, so the vote is ready in the same cycle.
  assign maj     = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
  assign bit_val = at_mid ? maj : maj_r;
  assign o_busy  = (state != IDLE);

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:   if (armed && !rxs) state_n = START;
      START: begin
        if (at_mid && maj)  state_n = IDLE;
        else if (at_end)    state_n = DATA;
      end
      DATA:   if (at_end && bit_idx == BW'(DATA_BITS - 1))
                state_n = par_en ? PARITY : STOP1;
      PARITY: if (at_end) state_n = STOP1;
      STOP1: begin
        if (two_stop) begin
          if (at_end) state_n = STOP2;
        end else if (at_mid) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      STOP2: begin
        if (at_mid) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div       <= DIV_W'(4);
      armed     <= 1'b0;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      two_stop  <= 1'b0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      maj_r     <= 1'b1;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        cnt       <= '0;
        bit_idx   <= '0;
        par_err   <= 1'b0;
        frame_err <= 1'b0;
        // A line held low after a frame never re-arms until it goes high.
        armed     <= (state_n == IDLE) && (armed || rxs);
        if (state_n == START) begin
          div      <= div_eff;
          par_en   <= i_parity_en;
          par_odd  <= i_parity_odd;
          two_stop <= i_two_stop;
        end
      end else begin
        armed <= 1'b0;
        cnt   <= (at_end || state_n == IDLE) ? '0 : cnt + DIV_W'(1);
        if (cnt == half - DIV_W'(1)) smp_a <= rxs;
        if (cnt == half)             smp_b <= rxs;
        if (at_mid)                  maj_r <= maj;
        if (state == DATA && at_end) begin
          shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + BW'(1);
        end
        if (state == PARITY && at_end)
          par_err <= (((^shreg) ^ bit_val) != par_odd);
        if ((state == STOP1 || state == STOP2) && at_mid && !maj)
          frame_err <= 1'b1;
      end
    end
  end

  // Output handshake: a word transfers on every cycle where o_rx_valid and
  // i_rx_ready are both high; o_rx_* hold the head until that happens.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, pop, wr;
  logic [EW-1:0] head;

  assign o_rx_valid = (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = o_rx_valid & i_rx_ready;
  assign wr         = done & (~full | pop);
  assign o_overrun  = done & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The stop-bit vote that completes the frame is folded in at push time.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {frame_err | ~maj, par_err, shreg};
  end

  assign head            = mem[rptr];
  assign o_rx_data       = o_rx_valid ? head[DATA_BITS-1:0] : '0;
  assign o_rx_parity_err = o_rx_valid & head[DATA_BITS];
  assign o_rx_frame_err  = o_rx_valid & head[DATA_BITS+1];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: bit-level line driver, frame-level reference model
// with an expected-word queue, per-cycle compare and directed literal checks.
module tb_uart_rx_fifo;
  localparam int DB = 8, DIV_W = 16, DEPTH = 4, W = DB + 2;

  logic             clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0;
  logic             pen = 1'b0, podd = 1'b0, two = 1'b0;
  logic [DIV_W-1:0] cpb = 16;
  logic [DB-1:0]    dout;
  logic             perr, ferr, valid, ovr, busy;

  uart_rx_fifo #(.DATA_BITS(DB), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_rx_data(rx), .i_clks_per_bit(cpb),
    .i_parity_en(pen), .i_parity_odd(podd), .i_two_stop(two),
    .o_rx_data(dout), .o_rx_parity_err(perr), .o_rx_frame_err(ferr),
    .o_rx_valid(valid), .i_rx_ready(ready), .o_overrun(ovr), .o_busy(busy)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int         n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_q[$];
  int         pend_cyc[$];
  logic [W-1:0] pend_word[$];
  int         bs_q[$], be_q[$];
  bit         chk_en = 1'b0;
  int         rdy_mode = 0;
  int         rise_cyc = 0, busy_cnt = 0, ovr_cnt = 0, pop_cnt = 0;
  logic [W-1:0] rise_word = '0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // compare process
  always @(negedge clk) begin
    bit comp, ev, eb;
    logic [W-1:0] w;
    if (valid && !prev_valid) begin
      rise_cyc  = cyc;
      rise_word = {ferr, perr, dout};
    end
    prev_valid = valid;
    if (busy) busy_cnt++;
    if (ovr) ovr_cnt++;
    if (valid && ready) pop_cnt++;
    if (chk_en) begin
      comp = (pend_cyc.size() != 0) && (pend_cyc[0] == cyc);
      ev   = (exp_q.size() != 0);
      chk("valid", valid, ev);
      if (ev) chk("head", {ferr, perr, dout}, exp_q[0]);
      chk("overrun", ovr, comp && exp_q.size() == DEPTH && !ready);
      eb = (bs_q.size() != 0) && cyc >= bs_q[0] && cyc <= be_q[0];
      chk("busy", busy, eb);
      if (ev && ready) void'(exp_q.pop_front());
      if (comp) begin
        w = pend_word.pop_front();
        void'(pend_cyc.pop_front());
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
      end
      if (be_q.size() != 0 && cyc >= be_q[0]) begin
        void'(bs_q.pop_front());
        void'(be_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic set_cfg(input int c, input bit p, input bit o, input bit t);
    cpb  = DIV_W'(c);
    pen  = p;
    podd = o;
    two  = t;
  endtask

  // Line bit k of the frame lasts N cycles; the word is due at mid-last-stop
  // (start detect takes 3 cycles through the synchroniser).
  task automatic send_frame(input int c, input logic [DB-1:0] d, input bit p,
                            input bit o, input bit t, input bit pflip,
                            input bit s1v, input bit s2v, input int glitch,
                            input bit scramble, output int f);
    int nn, last, comp;
    logic bq[$];
    nn = (c < 4) ? 4 : c;
    set_cfg(c, p, o, t);
    bq.push_back(1'b0);
    for (int i = 0; i < DB; i++) bq.push_back(d[i]);
    if (p) bq.push_back((^d) ^ o ^ pflip);
    bq.push_back(s1v);
    if (t) bq.push_back(s2v);
    last = bq.size() - 1;
    f    = cyc;
    comp = f + 3 + last * nn + nn / 2 + 1;
    pend_cyc.push_back(comp);
    pend_word.push_back({~s1v | (t & ~s2v), p & pflip, d});
    bs_q.push_back(f + 3);
    be_q.push_back(comp);
    for (int i = 0; i < bq.size(); i++) begin
      for (int k = 0; k < nn; k++) begin
        rx = bq[i];
        if (i * nn + k == glitch) rx = ~rx;
        if (scramble && i == 1 && k == 0) begin
          cpb  = DIV_W'($urandom_range(0, 65535));
          pen  = 1'($urandom_range(0, 1));
          podd = 1'($urandom_range(0, 1));
          two  = 1'($urandom_range(0, 1));
        end
        tick(1);
      end
    end
  endtask

  initial begin
    int f, p0, o0, nn, gap, gl;
    bit p, o, t, pf, s1, s2;
    logic [DB-1:0] d;

    // reset
    rst = 1'b1;
    tick(3);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", dout, 0);
    chk("rst_perr", perr, 0);
    chk("rst_ferr", ferr, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(20);

    // 8N1 N=16 0xA5: valid 157 cycles after pin fall
    rdy_mode = 0;
    send_frame(16, 8'hA5, 0, 0, 0, 0, 1, 1, -1, 0, f);
    idle(4);
    chk("a5_latency", rise_cyc - f, 157);
    chk("a5_word", rise_word, 10'h0A5);
    rdy_mode = 1;
    idle(3);
    chk("a5_popped", valid, 0);

    // 8E1 wrong parity, then 8O1 correct parity
    idle(10);
    send_frame(16, 8'h07, 1, 0, 0, 1, 1, 1, -1, 0, f);
    idle(4);
    chk("even_latency", rise_cyc - f, 173);
    chk("even_bad_par", rise_word, 10'h107);
    send_frame(16, 8'h07, 1, 1, 0, 0, 1, 1, -1, 0, f);
    idle(4);
    chk("odd_good_par", rise_word, 10'h007);

    // 8N2 with second stop low
    send_frame(16, 8'h96, 0, 0, 1, 0, 1, 0, -1, 0, f);
    idle(20);
    chk("stop2_latency", rise_cyc - f, 173);
    chk("stop2_ferr", rise_word, 10'h296);

    // break: line low for 30 bit times
    set_cfg(16, 0, 0, 0);
    p0 = pop_cnt;
    f = cyc;
    pend_cyc.push_back(f + 156);
    pend_word.push_back(10'h200);
    bs_q.push_back(f + 3);
    be_q.push_back(f + 156);
    rx = 1'b0;
    tick(30 * 16);
    idle(40);
    chk("break_words", pop_cnt - p0, 1);
    chk("break_word", rise_word, 10'h200);

    // 3-cycle low glitch: false start, back to IDLE at START cnt 9
    p0 = pop_cnt;
    busy_cnt = 0;
    set_cfg(16, 0, 0, 0);
    f = cyc;
    bs_q.push_back(f + 3);
    be_q.push_back(f + 12);
    rx = 1'b0;
    tick(3);
    idle(40);
    chk("glitch_busy", busy_cnt, 10);
    chk("glitch_nopush", pop_cnt - p0, 0);

    // single-cycle glitch at midpoint of data bit 2
    send_frame(16, 8'h00, 0, 0, 0, 0, 1, 1, 1 + 3 * 16 + 8, 0, f);
    idle(4);
    chk("mid_glitch", rise_word, 10'h000);

    // overrun: 5 back-to-back frames into a stalled 4-deep FIFO
    idle(10);
    rdy_mode = 0;
    o0 = ovr_cnt;
    for (int i = 0; i < 5; i++)
      send_frame(16, DB'(8'h11 * (i + 1)), 0, 0, 0, 0, 1, 1, -1, 0, f);
    idle(20);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_head", {valid, dout}, {1'b1, 8'h11});
    p0 = pop_cnt;
    rdy_mode = 1;
    tick(4);
    chk("drain_count", pop_cnt - p0, 4);
    chk("drain_empty", valid, 0);

    // reset mid-DATA
    idle(10);
    chk_en = 1'b0;
    set_cfg(16, 0, 0, 0);
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(40);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_overrun", ovr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", dout, 0);
    chk("mid_rst_perr", perr, 0);
    chk("mid_rst_ferr", ferr, 0);
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    pend_cyc.delete();
    pend_word.delete();
    bs_q.delete();
    be_q.delete();
    chk_en = 1'b1;
    idle(10);
    send_frame(16, 8'h3C, 0, 0, 0, 0, 1, 1, -1, 0, f);
    idle(4);
    chk("post_rst_word", rise_word, 10'h03C);

    // config changed mid-frame: old divisor kept
    idle(10);
    send_frame(16, 8'h5A, 0, 0, 0, 0, 1, 1, -1, 1, f);
    idle(10);
    chk("scramble_latency", rise_cyc - f, 157);
    chk("scramble_word", rise_word, 10'h05A);

    // divisor below 4 clamps to 4
    send_frame(2, 8'hC3, 0, 0, 0, 0, 1, 1, -1, 0, f);
    idle(10);
    chk("clamp_latency", rise_cyc - f, 43);
    chk("clamp_word", rise_word, 10'h0C3);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(0, 2);
      nn = $urandom_range(8, 24);
      d  = DB'($urandom_range(0, 255));
      p  = 1'($urandom_range(0, 1));
      o  = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      pf = ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      gl = ($urandom_range(0, 2) == 0) ?
           1 + (1 + $urandom_range(0, DB - 1)) * nn + nn / 2 : -1;
      send_frame(nn, d, p, o, t, pf, s1, s2, gl, 1'($urandom_range(0, 1)), f);
      if (!(t ? s2 : s1)) gap = 4 + $urandom_range(0, 8);
      else gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 2 * nn);
      if (gap > 0) idle(gap);
    end

    rdy_mode = 1;
    idle(300);
    chk("final_empty", valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised, runtime-configurable UART receiver with majority-vote sampling, parity/framing error detection and an output FIFO with valid/ready handshake. It is the next-generation serial receive front end: the asynchronous line comes in on one side, and buffered, error-tagged words go out on the other to a streaming consumer that may stall.

## Interface
- DATA_BITS, 8, data bits per frame (5..9), LSB first on the line
- DIV_W, 16, width of runtime clocks-per-bit divisor
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_rx_data  in  1  asynchronous UART line, idle high
- i_clks_per_bit  in  DIV_W  clocks per bit, Fclk/baud; values <4 treated as 4
- i_parity_en  in  1  1 = parity bit follows data
- i_parity_odd  in  1  1 = odd parity, 0 = even
- i_two_stop  in  1  1 = two stop bits expected
- o_rx_data  out  DATA_BITS  FIFO head data
- o_rx_parity_err  out  1  FIFO head parity error flag
- o_rx_frame_err  out  1  FIFO head framing error flag
- o_rx_valid  out  1  FIFO non-empty
- i_rx_ready  in  1  consumer accepts head when high with o_rx_valid
- o_overrun  out  1  one-cycle pulse: completed word dropped, FIFO full
- o_busy  out  1  receiver FSM not in IDLE

## Operation
- Synchroniser: 2 flops on i_rx_data, both reset to 1; all logic uses the synchronised line (rxs).
- Config (i_clks_per_bit, i_parity_en, i_parity_odd, i_two_stop) latched on start detection; changes mid-frame ignored until next frame.
- Bit timing: counter cnt runs 0..N-1 per bit, N = latched divisor; M = N>>1. Samples taken at cnt M-1, M, M+1; bit value = majority of 3.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: if armed and rxs==0 -> START, cnt=0 next cycle. armed sets when rxs==1 in IDLE; cleared on leaving IDLE.
- START: at cnt M+1, majority==1 -> IDLE (false start, nothing pushed); else continue to cnt N-1 -> DATA.
- DATA: at cnt N-1 store majority into bit idx (LSB first); after DATA_BITS bits -> PARITY if enabled, else STOP1.
- PARITY: parity_err = (XOR of data ^ parity bit) != i_parity_odd; at cnt N-1 -> STOP1. parity_err=0 when disabled.
- STOP1: majority==0 sets frame_err. Two stop: at cnt N-1 -> STOP2. One stop: word completes at cnt M+1 -> IDLE.
- STOP2: majority==0 sets frame_err; word completes at cnt M+1 -> IDLE.
- Completion: {frame_err, parity_err, data} pushed to FIFO every completed frame, errors included.
- Break/line stuck low after frame: armed stays 0, no new start until rxs returns high.
- FIFO: show-ahead; head on o_rx_* while o_rx_valid. Pop when o_rx_valid && i_rx_ready. Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
- Full and push without pop: word dropped, FIFO contents unchanged, o_overrun=1 for that cycle. Full with simultaneous pop and push: both happen, no overrun. Empty: pop ignored.
- o_rx_data/flags are don't-care while o_rx_valid=0.

## Timing
- Reset values: o_rx_valid=0, o_overrun=0, o_busy=0, o_rx_parity_err=0, o_rx_frame_err=0, o_rx_data=0; FIFO empty, FSM IDLE, armed=0, cnt=0. Reset mid-frame discards the partial word.
- Pin falls in cycle 0 -> rxs low in cycle 2 -> START cnt=0 in cycle 3. Bit b, count k occurs in cycle 3+b*N+k (start bit b=0).
- Push at completion cycle; o_rx_valid high the following cycle. 8N1, N=16: completion cycle 156, o_rx_valid in cycle 157.
- Pop: head advances the cycle after handshake; o_rx_valid drops the cycle after the last pop.
- o_busy high from START entry through completion cycle.
- Back-to-back frames accepted with zero idle bits (completion at mid-stop leaves half a bit of slack).

## Test plan
- 8N1, N=16, send 0xA5 -> one word 0xA5, both errors 0, o_rx_valid high cycle 157 after pin fall, i_rx_ready=1 pops it next cycle.
- 8E1, send 0x07 with wrong parity bit 0 -> word 0x07, o_rx_parity_err=1; repeat with 8O1 correct bit 0 -> err 0.
- 8N2, second stop bit driven 0 -> o_rx_frame_err=1, data intact; line held low 30 bits (break) -> exactly one word 0x00 frame_err=1, no further words until line high.
- Low glitch of 3 cycles in IDLE, N=16 -> returns to IDLE at START cnt 9, no push; single-cycle glitch at a data-bit midpoint -> majority rejects it, correct data.
- FIFO_DEPTH=4, i_rx_ready=0, send 5 back-to-back frames -> 4 stored, o_overrun pulses once on 5th; then ready=1 drains 4 in order on 4 consecutive cycles.
- Assert rst mid-DATA -> all outputs at reset values next cycle, following clean frame 0x3C received correctly; change i_clks_per_bit mid-frame -> current frame uses old divisor.
